// File: rtl/tlram_pkg.sv
// Shared types and helpers for the TileLink-UH burst RAM.
package tlram_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    ACK      = 3'd0,
    ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2
  } state_e;

  // Number of beats minus one for a transfer of 2^size bytes on a 2^log2b-byte bus.
  function automatic int unsigned beats_m1(input int unsigned size, input int unsigned log2b);
    if (size > log2b) begin
      return (32'd1 << (size - log2b)) - 32'd1;
    end else begin
      return 32'd0;
    end
  endfunction

endpackage

// File: rtl/tlram_sram_1rw.sv
// Behavioural single-port SRAM: byte-masked write, registered read (1-cycle latency).
module tlram_sram_1rw #(
  parameter int DEPTH_LOG2 = 12,
  parameter int BEAT_BYTES = 8
) (
  input  logic                    clock,
  input  logic                    en,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [BEAT_BYTES-1:0]   wmask,
  input  logic [8*BEAT_BYTES-1:0] wdata,
  output logic [8*BEAT_BYTES-1:0] rdata
);

  logic [8*BEAT_BYTES-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Array access: masked byte writes, or a read into the output register.
  always_ff @(posedge clock) begin
    if (en && we) begin
      for (int b = 0; b < BEAT_BYTES; b++) begin
        if (wmask[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tlram_burst.sv
// TileLink-UH slave RAM with multi-beat bursts and Denied responses for
// out-of-window addresses. One 1RW SRAM and a single D response slot.
module tlram_burst
  import tlram_pkg::*;
#(
  parameter int          BEAT_BYTES   = 8,
  parameter int          ADDR_WIDTH   = 33,
  parameter int          SOURCE_WIDTH = 10,
  parameter int          SIZE_WIDTH   = 3,
  parameter int          DEPTH_LOG2   = 12,
  parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_8000_0000,
  parameter int          MAX_SIZE     = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    auto_in_a_ready,
  input  logic                    auto_in_a_valid,
  input  logic [2:0]              auto_in_a_bits_opcode,
  input  logic [SIZE_WIDTH-1:0]   auto_in_a_bits_size,
  input  logic [SOURCE_WIDTH-1:0] auto_in_a_bits_source,
  input  logic [ADDR_WIDTH-1:0]   auto_in_a_bits_address,
  input  logic [BEAT_BYTES-1:0]   auto_in_a_bits_mask,
  input  logic [8*BEAT_BYTES-1:0] auto_in_a_bits_data,
  input  logic                    auto_in_d_ready,
  output logic                    auto_in_d_valid,
  output logic [2:0]              auto_in_d_bits_opcode,
  output logic [SIZE_WIDTH-1:0]   auto_in_d_bits_size,
  output logic [SOURCE_WIDTH-1:0] auto_in_d_bits_source,
  output logic                    auto_in_d_bits_denied,
  output logic                    auto_in_d_bits_corrupt,
  output logic [8*BEAT_BYTES-1:0] auto_in_d_bits_data
);

  localparam int LOG2B  = $clog2(BEAT_BYTES);
  localparam int HI_LSB = LOG2B + DEPTH_LOG2;
  localparam int DW     = 8 * BEAT_BYTES;

  // Request decode
  logic                  in_win_s;
  logic                  a_get_s;
  logic [DEPTH_LOG2-1:0] a_idx_s;
  logic [DEPTH_LOG2-1:0] a_last_s;
  logic                  a_ready_s;
  logic                  a_fire_s;
  logic                  d_fire_s;
  logic                  slot_free_s;
  logic                  unused_addr_s;

  // FSM and burst context
  state_e                  state_r, state_n;
  logic [DEPTH_LOG2-1:0]   cnt_r, cnt_n;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [DEPTH_LOG2-1:0]   last_r;
  logic [SIZE_WIDTH-1:0]   size_r;
  logic [SOURCE_WIDTH-1:0] source_r;
  logic                    denied_r;
  logic                    latch_s;

  // D slot load request
  logic                    ld_s;
  logic [2:0]              ld_op_s;
  logic [SIZE_WIDTH-1:0]   ld_size_s;
  logic [SOURCE_WIDTH-1:0] ld_source_s;
  logic                    ld_denied_s;
  logic                    ld_corrupt_s;
  logic                    ld_read_s;

  // D slot registers
  logic                    d_valid_r;
  logic [2:0]              d_opcode_r;
  logic [SIZE_WIDTH-1:0]   d_size_r;
  logic [SOURCE_WIDTH-1:0] d_source_r;
  logic                    d_denied_r;
  logic                    d_corrupt_r;
  logic                    fresh_r;
  logic [DW-1:0]           hold_r;

  // SRAM interface
  logic                  sram_en_raw_s;
  logic                  sram_en_s;
  logic                  sram_we_s;
  logic [DEPTH_LOG2-1:0] sram_addr_s;
  logic [DW-1:0]         sram_rdata_s;

  assign in_win_s    = (auto_in_a_bits_address[ADDR_WIDTH-1:HI_LSB] == BASE_ADDR[ADDR_WIDTH-1:HI_LSB]);
  assign a_get_s     = (auto_in_a_bits_opcode == GET);
  assign a_idx_s     = auto_in_a_bits_address[HI_LSB-1:LOG2B];
  assign a_last_s    = DEPTH_LOG2'(beats_m1(32'(auto_in_a_bits_size), LOG2B));
  assign slot_free_s = ~d_valid_r | auto_in_d_ready;
  assign d_fire_s    = d_valid_r & auto_in_d_ready;
  assign a_fire_s    = auto_in_a_valid & a_ready_s;
  // Reset must stop any in-flight burst from writing on the reset cycle.
  assign sram_en_s   = sram_en_raw_s & ~reset;
  // Low address bits carry only alignment and are not needed beyond decode.
  assign unused_addr_s = ^auto_in_a_bits_address;

  // A-channel ready: per-state flow control, closed while reset is held.
  always_comb begin
    a_ready_s = 1'b0;
    case (state_r)
      IDLE:    a_ready_s = slot_free_s;
      WBURST:  a_ready_s = (cnt_r == last_r) ? slot_free_s : 1'b1;
      RBURST:  a_ready_s = 1'b0;
      default: a_ready_s = 1'b0;
    endcase
    if (reset) begin
      a_ready_s = 1'b0;
    end else begin
      a_ready_s = a_ready_s;
    end
  end

  // Next-state, SRAM access and D-slot load decisions.
  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r;
    latch_s       = 1'b0;
    sram_en_raw_s = 1'b0;
    sram_we_s     = 1'b0;
    sram_addr_s   = idx_r | cnt_r;
    ld_s          = 1'b0;
    ld_op_s       = ACK;
    ld_size_s     = size_r;
    ld_source_s   = source_r;
    ld_denied_s   = 1'b0;
    ld_corrupt_s  = 1'b0;
    ld_read_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (a_fire_s) begin
          sram_en_raw_s = in_win_s;
          sram_addr_s   = a_idx_s;
          ld_size_s     = auto_in_a_bits_size;
          ld_source_s   = auto_in_a_bits_source;
          ld_denied_s   = ~in_win_s;
          if (a_get_s) begin
            ld_s         = 1'b1;
            ld_op_s      = ACK_DATA;
            ld_corrupt_s = ~in_win_s;
            ld_read_s    = in_win_s;
            if (a_last_s != '0) begin
              state_n = RBURST;
              cnt_n   = DEPTH_LOG2'(1);
              latch_s = 1'b1;
            end else begin
              cnt_n = '0;
            end
          end else begin
            sram_we_s = 1'b1;
            if (a_last_s == '0) begin
              ld_s  = 1'b1;
              cnt_n = '0;
            end else begin
              state_n = WBURST;
              cnt_n   = DEPTH_LOG2'(1);
              latch_s = 1'b1;
            end
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      WBURST: begin
        if (a_fire_s) begin
          sram_en_raw_s = ~denied_r;
          sram_we_s     = 1'b1;
          if (cnt_r == last_r) begin
            ld_s        = 1'b1;
            ld_denied_s = denied_r;
            state_n     = IDLE;
            cnt_n       = '0;
          end else begin
            cnt_n = cnt_r + DEPTH_LOG2'(1);
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      RBURST: begin
        if (slot_free_s) begin
          sram_en_raw_s = ~denied_r;
          ld_s          = 1'b1;
          ld_op_s       = ACK_DATA;
          ld_denied_s   = denied_r;
          ld_corrupt_s  = denied_r;
          ld_read_s     = ~denied_r;
          if (cnt_r == last_r) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + DEPTH_LOG2'(1);
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State register and burst context captured from the first beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      idx_r    <= '0;
      last_r   <= '0;
      size_r   <= '0;
      source_r <= '0;
      denied_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (latch_s) begin
        idx_r    <= a_idx_s;
        last_r   <= a_last_s;
        size_r   <= auto_in_a_bits_size;
        source_r <= auto_in_a_bits_source;
        denied_r <= ~in_win_s;
      end
    end
  end

  // D response slot: fields load with a beat and stay put until it fires.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_r   <= 1'b0;
      d_opcode_r  <= 3'd0;
      d_size_r    <= '0;
      d_source_r  <= '0;
      d_denied_r  <= 1'b0;
      d_corrupt_r <= 1'b0;
    end else if (ld_s) begin
      d_valid_r   <= 1'b1;
      d_opcode_r  <= ld_op_s;
      d_size_r    <= ld_size_s;
      d_source_r  <= ld_source_s;
      d_denied_r  <= ld_denied_s;
      d_corrupt_r <= ld_corrupt_s;
    end else if (d_fire_s) begin
      d_valid_r <= 1'b0;
    end
  end

  // Data path: SRAM output is live for one cycle, then the hold copy takes over.
  always_ff @(posedge clock) begin
    if (reset) begin
      fresh_r <= 1'b0;
      hold_r  <= '0;
    end else begin
      fresh_r <= ld_s & ld_read_s;
      if (ld_s) begin
        hold_r <= '0;
      end else if (fresh_r) begin
        hold_r <= sram_rdata_s;
      end
    end
  end

  tlram_sram_1rw #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BEAT_BYTES (BEAT_BYTES)
  ) u_sram (
    .clock (clock),
    .en    (sram_en_s),
    .we    (sram_we_s),
    .addr  (sram_addr_s),
    .wmask (auto_in_a_bits_mask),
    .wdata (auto_in_a_bits_data),
    .rdata (sram_rdata_s)
  );

  assign auto_in_a_ready        = a_ready_s;
  assign auto_in_d_valid        = d_valid_r;
  assign auto_in_d_bits_opcode  = d_opcode_r;
  assign auto_in_d_bits_size    = d_size_r;
  assign auto_in_d_bits_source  = d_source_r;
  assign auto_in_d_bits_denied  = d_denied_r;
  assign auto_in_d_bits_corrupt = d_corrupt_r;
  assign auto_in_d_bits_data    = fresh_r ? sram_rdata_s : hold_r;

endmodule

// File: tb/tb_tlram_burst.sv
// Scoreboard bench for tlram_burst: directed A-channel traffic, D-channel monitor.
module tb_tlram_burst;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_ready, a_valid;
  logic [2:0]  a_op, a_sz;
  logic [9:0]  a_src;
  logic [32:0] a_addr;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_ready, d_valid;
  logic [2:0]  d_op, d_sz;
  logic [9:0]  d_src;
  logic        d_den, d_cor;
  logic [63:0] d_data;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  sz;
    logic [9:0]  src;
    logic        den;
    logic        cor;
    logic [63:0] data;
    bit          chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [81:0] prev_fields;
  bit   watch = 1'b0;
  bit   touched = 1'b0;
  time  t0, t1;

  localparam logic [32:0] A10 = 33'h0_8000_0010;
  localparam logic [32:0] A40 = 33'h0_8000_0040;
  localparam logic [3:0]  PAT = 4'b1001;

  always #5 clk = ~clk;

  tlram_burst dut (
    .clock                  (clk),
    .reset                  (reset),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_bits_opcode  (a_op),
    .auto_in_a_bits_size    (a_sz),
    .auto_in_a_bits_source  (a_src),
    .auto_in_a_bits_address (a_addr),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_bits_opcode  (d_op),
    .auto_in_d_bits_size    (d_sz),
    .auto_in_d_bits_source  (d_src),
    .auto_in_d_bits_denied  (d_den),
    .auto_in_d_bits_corrupt (d_cor),
    .auto_in_d_bits_data    (d_data)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] sz, input logic [9:0] src,
                      input logic den, input logic cor, input logic [63:0] data, input bit cd);
    exp_t e;
    e.op = op; e.sz = sz; e.src = src; e.den = den; e.cor = cor; e.data = data; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  // Present one A beat (called just after a negedge); returns at the negedge after it fires.
  task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [9:0] src,
                      input logic [32:0] addr, input logic [7:0] mask, input logic [63:0] data);
    bit fired;
    fired = 1'b0;
    a_valid = 1'b1; a_op = op; a_sz = sz; a_src = src; a_addr = addr; a_mask = mask; a_data = data;
    for (int k = 0; k < 100 && !fired; k++) begin
      #1;
      if (a_ready) begin
        @(posedge clk);
        fired = 1'b1;
      end
      @(negedge clk);
    end
    if (!fired) chk("a_fire_timeout", 96'd0, 96'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", 96'(exp_q.size()), 96'd0);
  endtask

  // D monitor: sampled late in the low phase so inputs and DUT outputs are settled.
  always @(negedge clk) begin
    logic [81:0] cur;
    exp_t e;
    #3;
    cur = {d_op, d_sz, d_src, d_den, d_cor, d_data};
    if (mon_en) begin
      if (prev_stall) begin
        chk("d_stable", {13'd0, d_valid, cur}, {13'd0, 1'b1, prev_fields});
      end
      if (d_valid && d_ready) begin
        if (exp_q.size() == 0) begin
          chk("d_unexpected", {14'd0, cur}, 96'd0);
        end else begin
          e = exp_q.pop_front();
          chk("d_beat", {14'd0, d_op, d_sz, d_src, d_den, d_cor, (e.chk_data ? d_data : 64'd0)},
                        {14'd0, e.op, e.sz, e.src, e.den, e.cor, (e.chk_data ? e.data : 64'd0)});
        end
      end
      prev_stall  = d_valid && !d_ready;
      prev_fields = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Track whether the SRAM is enabled while a denied access is in flight.
  always @(negedge clk) begin
    #2;
    if (watch && dut.sram_en_s) touched = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; a_valid = 1'b0; a_op = 3'd0; a_sz = 3'd0; a_src = 10'd0;
    a_addr = 33'd0; a_mask = 8'd0; a_data = 64'd0; d_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_d_valid", 96'(d_valid), 96'd0);
    chk("rst_a_ready", 96'(a_ready), 96'd1);
    chk("rst_d_fields", 96'({d_op, d_sz, d_src, d_den, d_cor}), 96'd0);
    mon_en = 1'b1;

    // Full put then get of one beat
    push(3'd0, 3'd3, 10'd1, 1'b0, 1'b0, 64'd0, 1'b0);
    send(3'd0, 3'd3, 10'd1, A10, 8'hFF, 64'h1122334455667788);
    a_valid = 1'b0; drain(); repeat (2) @(negedge clk);
    chk("idle_before_get", 96'(d_valid), 96'd0);
    push(3'd1, 3'd3, 10'd2, 1'b0, 1'b0, 64'h1122334455667788, 1'b1);
    send(3'd4, 3'd3, 10'd2, A10, 8'hFF, 64'd0);
    a_valid = 1'b0;
    chk("get_latency", 96'(d_valid), 96'd1);
    drain();

    // Partial put over the low four bytes
    push(3'd0, 3'd3, 10'd3, 1'b0, 1'b0, 64'd0, 1'b0);
    send(3'd1, 3'd3, 10'd3, A10, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    a_valid = 1'b0; drain();
    push(3'd1, 3'd3, 10'd4, 1'b0, 1'b0, 64'h11223344AAAAAAAA, 1'b1);
    send(3'd4, 3'd3, 10'd4, A10, 8'hFF, 64'd0);
    a_valid = 1'b0; drain();

    // 8-beat put, then 8-beat get under a 1,0,0,1 d_ready pattern
    push(3'd0, 3'd6, 10'd5, 1'b0, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) send(3'd0, 3'd6, 10'd5, A40, 8'hFF, 64'(i));
    a_valid = 1'b0; drain();
    for (int i = 0; i < 8; i++) push(3'd1, 3'd6, 10'd6, 1'b0, 1'b0, 64'(i), 1'b1);
    send(3'd4, 3'd6, 10'd6, A40, 8'hFF, 64'd0);
    a_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d_ready = PAT[3 - (i % 4)];
      @(negedge clk);
    end
    d_ready = 1'b1; drain();

    // Out-of-window get
    touched = 1'b0; watch = 1'b1;
    push(3'd1, 3'd3, 10'd7, 1'b1, 1'b1, 64'd0, 1'b1);
    send(3'd4, 3'd3, 10'd7, 33'h0_0000_1000, 8'hFF, 64'd0);
    a_valid = 1'b0; drain(); repeat (2) @(negedge clk);
    watch = 1'b0;
    chk("denied_sram_idle", 96'(touched), 96'd0);

    // Back-to-back single-beat gets, one accept per cycle
    for (int i = 0; i < 4; i++) push(3'd1, 3'd3, 10'd8, 1'b0, 1'b0, 64'(i), 1'b1);
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      send(3'd4, 3'd3, 10'd8, A40 + 33'(8 * i), 8'hFF, 64'd0);
      chk("b2b_d_valid", 96'(d_valid), 96'd1);
    end
    t1 = $time;
    a_valid = 1'b0;
    chk("b2b_cycles", 96'((t1 - t0) / 10), 96'd4);
    drain();

    // With d_ready low the slot fills and a_ready drops
    d_ready = 1'b0;
    push(3'd1, 3'd3, 10'd9, 1'b0, 1'b0, 64'd4, 1'b1);
    send(3'd4, 3'd3, 10'd9, A40 + 33'd32, 8'hFF, 64'd0);
    a_addr = A40 + 33'd40;
    #1;
    chk("stall_a_ready", 96'(a_ready), 96'd0);
    @(negedge clk);
    d_ready = 1'b1;
    push(3'd1, 3'd3, 10'd9, 1'b0, 1'b0, 64'd5, 1'b1);
    send(3'd4, 3'd3, 10'd9, A40 + 33'd40, 8'hFF, 64'd0);
    a_valid = 1'b0; drain();

    // Reset during an 8-beat put after three beats
    for (int i = 0; i < 3; i++) send(3'd0, 3'd6, 10'd10, A40, 8'hFF, 64'(100 + i));
    a_data = 64'd103;
    reset = 1'b1; mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b0; a_valid = 1'b0;
    #1;
    chk("midrst_d_valid", 96'(d_valid), 96'd0);
    chk("midrst_a_ready", 96'(a_ready), 96'd1);
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++)
      push(3'd1, 3'd6, 10'd11, 1'b0, 1'b0, (i < 3) ? 64'(100 + i) : 64'(i), 1'b1);
    send(3'd4, 3'd6, 10'd11, A40, 8'hFF, 64'd0);
    a_valid = 1'b0; drain();
    repeat (3) @(negedge clk);
    chk("queue_empty", 96'(exp_q.size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
